// File: rtl/clint_timer.sv
// rtl/clint_timer.sv - core-local interruptor: msip, mtime/mtimecmp and mtip on a simple memory bus
// mtime advances once per 2*(clk_divider_rtc+1) clocks; all bus accesses answer one cycle later.
module clint_timer #(
   parameter logic [31:0] clint_base_addr = 32'h0200_0000,
   parameter int          clk_divider_rtc = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        mem_valid,
   input  logic        mem_instr,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic [31:0] mem_rdata,
   output logic        mem_ready,
   output logic        clint_msip,
   output logic        clint_mtip
);

   localparam int CW = $clog2(clk_divider_rtc + 2);
   localparam logic [CW-1:0] DIV_MAX = CW'(clk_divider_rtc);

   localparam logic [29:0] W_MSIP     = 30'h0000;
   localparam logic [29:0] W_CMP_LO   = 30'h1000;
   localparam logic [29:0] W_CMP_HI   = 30'h1001;
   localparam logic [29:0] W_MTIME_LO = 30'h2FFE;
   localparam logic [29:0] W_MTIME_HI = 30'h2FFF;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          phase_q, phase_d;
   logic [63:0]   mtime_q, mtime_d;
   logic [63:0]   mtimecmp_q, mtimecmp_d;
   logic          msip_q, msip_d;
   logic          ready_q, ready_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          mtip_q, msip_out_q;

   logic [31:0] offset;
   logic [29:0] word;
   logic        wr_en, tick, wrap;
   logic [31:0] rd_val;
   logic        unused_bits;

   assign offset      = mem_addr - clint_base_addr;
   assign word        = offset[31:2];
   assign unused_bits = &{1'b0, mem_instr, offset[1:0]};
   assign wr_en       = mem_valid && (mem_wstrb != 4'b0000);
   assign wrap        = (cnt_q == DIV_MAX);
   assign tick        = wrap && !phase_q;

   function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                         input logic [3:0] strb);
      logic [31:0] res;
      res = old_v;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
      end
      return res;
   endfunction

   always_comb begin
      rd_val = 32'h0;
      case (word)
         W_MSIP:     rd_val = {31'h0, msip_q};
         W_CMP_LO:   rd_val = mtimecmp_q[31:0];
         W_CMP_HI:   rd_val = mtimecmp_q[63:32];
         W_MTIME_LO: rd_val = mtime_q[31:0];
         W_MTIME_HI: rd_val = mtime_q[63:32];
         default:    rd_val = 32'h0;
      endcase
   end

   always_comb begin
      cnt_d      = wrap ? '0 : cnt_q + 1'b1;
      phase_d    = wrap ? ~phase_q : phase_q;
      mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
      mtimecmp_d = mtimecmp_q;
      msip_d     = msip_q;
      // A bus write to either mtime half overrides the whole tick increment.
      if (wr_en) begin
         case (word)
            W_MSIP:     msip_d = mem_wstrb[0] ? mem_wdata[0] : msip_q;
            W_CMP_LO:   mtimecmp_d[31:0]  = merge(mtimecmp_q[31:0], mem_wdata, mem_wstrb);
            W_CMP_HI:   mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], mem_wdata, mem_wstrb);
            W_MTIME_LO: mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], mem_wdata, mem_wstrb)};
            W_MTIME_HI: mtime_d = {merge(mtime_q[63:32], mem_wdata, mem_wstrb), mtime_q[31:0]};
            default:    ;
         endcase
      end
      ready_d = mem_valid;
      rdata_d = mem_valid ? rd_val : 32'h0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q      <= '0;
         phase_q    <= 1'b0;
         mtime_q    <= 64'h0;
         mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
         msip_q     <= 1'b0;
         ready_q    <= 1'b0;
         rdata_q    <= 32'h0;
         mtip_q     <= 1'b0;
         msip_out_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         phase_q    <= phase_d;
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         msip_q     <= msip_d;
         ready_q    <= ready_d;
         rdata_q    <= rdata_d;
         mtip_q     <= (mtime_q >= mtimecmp_q);
         msip_out_q <= msip_q;
      end
   end

   assign mem_ready  = ready_q;
   assign mem_rdata  = rdata_q;
   assign clint_mtip = mtip_q;
   assign clint_msip = msip_out_q;

endmodule

// File: tb/tb_clint_timer.sv
// tb/tb_clint_timer.sv - directed self-checking bench for clint_timer
module tb_clint_timer;

   localparam logic [31:0] BASE = 32'h0200_0000;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        mem_valid = 1'b0;
   logic        mem_instr = 1'b0;
   logic [31:0] mem_addr = 32'h0;
   logic [31:0] mem_wdata = 32'h0;
   logic [3:0]  mem_wstrb = 4'h0;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        clint_msip;
   logic        clint_mtip;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic [31:0] r;

   clint_timer #(.clint_base_addr(BASE), .clk_divider_rtc(4)) dut (
      .clock(clock), .reset(reset), .mem_valid(mem_valid), .mem_instr(mem_instr),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .clint_msip(clint_msip), .clint_mtip(clint_mtip)
   );

   always #5 clock = ~clock;

   // Edge number since reset release: cyc==n right after the n-th rising edge.
   always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic xfer(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       output logic [31:0] rd);
      @(negedge clock);
      mem_valid = 1'b1;
      mem_addr  = a;
      mem_wdata = wd;
      mem_wstrb = ws;
      @(posedge clock);
      #1;
      chk("ready", {31'h0, mem_ready}, 32'h1);
      rd = mem_rdata;
      mem_valid = 1'b0;
      mem_wstrb = 4'h0;
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] v;
      xfer(a, 32'h0, 4'h0, v);
      chk(tag, v, exp);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
      logic [31:0] v;
      xfer(a, wd, ws, v);
   endtask

   initial begin
      repeat (3) @(posedge clock);
      #1;
      chk("rst_ready", {31'h0, mem_ready}, 32'h0);
      chk("rst_rdata", mem_rdata, 32'h0);
      chk("rst_msip", {31'h0, clint_msip}, 32'h0);
      chk("rst_mtip", {31'h0, clint_mtip}, 32'h0);
      @(negedge clock);
      reset = 1'b0;

      wait_cyc(50);
      rd_chk("mtime_50clk", BASE + 32'hBFF8, 32'd5);
      chk("mtip_idle", {31'h0, clint_mtip}, 32'h0);
      chk("msip_idle", {31'h0, clint_msip}, 32'h0);

      wr(BASE + 32'h4000, 32'h20, 4'hF);
      wr(BASE + 32'h4004, 32'h0, 4'hF);
      wait_cyc(315);
      chk("mtip_at_match_edge", {31'h0, clint_mtip}, 32'h0);
      wait_cyc(316);
      chk("mtip_rise", {31'h0, clint_mtip}, 32'h1);
      wr(BASE + 32'h4000, 32'hFFFF_FFFF, 4'hF);
      chk("mtip_hold", {31'h0, clint_mtip}, 32'h1);
      wait_cyc(318);
      chk("mtip_fall", {31'h0, clint_mtip}, 32'h0);

      wr(BASE, 32'hFFFF_FFFF, 4'hF);
      chk("msip_lag", {31'h0, clint_msip}, 32'h0);
      @(posedge clock);
      #1;
      chk("msip_set", {31'h0, clint_msip}, 32'h1);
      rd_chk("msip_read", BASE, 32'h1);
      wr(BASE, 32'h0, 4'hF);
      @(posedge clock);
      #1;
      chk("msip_clr", {31'h0, clint_msip}, 32'h0);

      // Edge 325 is a tick: the lo write must suppress the increment and any carry.
      wait_cyc(323);
      wr(BASE + 32'hBFFC, 32'h0, 4'hF);
      wait_cyc(324);
      wr(BASE + 32'hBFF8, 32'hFFFF_FFFF, 4'hF);
      rd_chk("wr_tick_lo", BASE + 32'hBFF8, 32'hFFFF_FFFF);
      rd_chk("wr_tick_hi", BASE + 32'hBFFC, 32'h0);
      wait_cyc(335);
      rd_chk("carry_lo", BASE + 32'hBFF8, 32'h0);
      rd_chk("carry_hi", BASE + 32'hBFFC, 32'h1);
      wr(BASE + 32'hBFF8, 32'hFFFF_FFFF, 4'hF);
      rd_chk("nocarry_hi", BASE + 32'hBFFC, 32'h1);
      rd_chk("nocarry_lo", BASE + 32'hBFF8, 32'hFFFF_FFFF);
      wait_cyc(344);
      rd_chk("read_at_tick", BASE + 32'hBFF8, 32'hFFFF_FFFF);
      rd_chk("after_tick_lo", BASE + 32'hBFF8, 32'h0);
      rd_chk("after_tick_hi", BASE + 32'hBFFC, 32'h2);

      @(negedge clock);
      mem_valid = 1'b1;
      mem_addr  = BASE;
      mem_wdata = 32'h1;
      mem_wstrb = 4'hF;
      @(posedge clock);
      #1;
      chk("pre_rst_ready", {31'h0, mem_ready}, 32'h1);
      mem_valid = 1'b0;
      mem_wstrb = 4'h0;
      reset = 1'b1;
      @(posedge clock);
      #1;
      chk("midrst_ready", {31'h0, mem_ready}, 32'h0);
      chk("midrst_rdata", mem_rdata, 32'h0);
      chk("midrst_msip", {31'h0, clint_msip}, 32'h0);
      chk("midrst_mtip", {31'h0, clint_mtip}, 32'h0);
      @(negedge clock);
      reset = 1'b0;
      rd_chk("rst_msip_reg", BASE, 32'h0);
      rd_chk("rst_cmp_lo", BASE + 32'h4000, 32'hFFFF_FFFF);
      wait_cyc(3);
      rd_chk("rst_mtime_lo", BASE + 32'hBFF8, 32'h0);
      rd_chk("first_tick_pre", BASE + 32'hBFF8, 32'h0);
      rd_chk("first_tick_post", BASE + 32'hBFF8, 32'h1);
      rd_chk("rst_cmp_hi", BASE + 32'h4004, 32'hFFFF_FFFF);

      wr(BASE + 32'h4000, 32'h0000_AB00, 4'b0010);
      rd_chk("byte_wr", BASE + 32'h4000, 32'hFFFF_ABFF);

      rd_chk("unmapped", BASE + 32'h1234, 32'h0);
      rd_chk("below_base", BASE - 32'h4, 32'h0);
      wr(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
      rd_chk("unmapped_wr", BASE + 32'h10, 32'h0);

      @(negedge clock);
      mem_valid = 1'b1;
      mem_instr = 1'b1;
      mem_addr  = BASE + 32'h4004;
      mem_wstrb = 4'h0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clock);
         #1;
         chk($sformatf("b2b_ready%0d", i), {31'h0, mem_ready}, 32'h1);
         chk($sformatf("b2b_rdata%0d", i), mem_rdata, 32'hFFFF_FFFF);
      end
      mem_valid = 1'b0;
      mem_instr = 1'b0;
      @(posedge clock);
      #1;
      chk("idle_ready", {31'h0, mem_ready}, 32'h0);
      chk("idle_rdata", mem_rdata, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
